// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller.
// Holds stage indices, the controller state enum and the per-hazard
// stall/flush patterns, all built from the stage indices so a reordering
// of the pipeline registers only needs to touch this file.
package pipe_ctrl_pkg;

    localparam int NUM_STG   = 5;
    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

    typedef logic [NUM_STG-1:0] stg_vec_t;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    function automatic stg_vec_t stg_bit(input int idx);
        return stg_vec_t'(1) << idx;
    endfunction

    localparam stg_vec_t STG_NONE = '0;

    // Memory wait: freeze everything upstream of MEM/WB, bubble into WB.
    localparam stg_vec_t STALL_MEM = stg_bit(STG_PC) | stg_bit(STG_IFID) |
                                     stg_bit(STG_IDEX) | stg_bit(STG_EXMEM);
    localparam stg_vec_t FLUSH_MEM = stg_bit(STG_MEMWB);

    // Redirect: kill the two younger instructions behind EX.
    localparam stg_vec_t FLUSH_REDIR = stg_bit(STG_IFID) | stg_bit(STG_IDEX);

    localparam stg_vec_t STALL_EX = stg_bit(STG_PC) | stg_bit(STG_IFID) | stg_bit(STG_IDEX);
    localparam stg_vec_t FLUSH_EX = stg_bit(STG_EXMEM);

    localparam stg_vec_t STALL_LU = stg_bit(STG_PC) | stg_bit(STG_IFID);
    localparam stg_vec_t FLUSH_LU = stg_bit(STG_IDEX);

    localparam stg_vec_t STALL_IF = stg_bit(STG_PC);
    localparam stg_vec_t FLUSH_IF = stg_bit(STG_IFID);

    // Pending redirect: hold PC, keep dropping whatever fetch returns.
    localparam stg_vec_t STALL_PEND     = stg_bit(STG_PC);
    localparam stg_vec_t FLUSH_PEND     = stg_bit(STG_IFID);
    localparam stg_vec_t FLUSH_PEND_MEM = stg_bit(STG_MEMWB) | stg_bit(STG_IFID);

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect bundle between the pipeline datapath and pipe_ctrl.
//   master : the controller (consumes hazard requests, drives stall/flush/PC load)
//   slave  : the datapath side (raises hazard requests, obeys stall/flush/PC load)
interface pipe_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             jump_en_i;
    logic [XLEN-1:0]  jump_addr_i;
    logic             trap_en_i;
    logic [XLEN-1:0]  trap_addr_i;
    logic             load_use_i;
    logic             ex_busy_i;
    logic             if_stall_i;
    logic             mem_stall_i;
    logic [4:0]       stall_o;
    logic [4:0]       flush_o;
    logic             jump_en_o;
    logic [XLEN-1:0]  jump_addr_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        input  jump_en_i, jump_addr_i, trap_en_i, trap_addr_i,
               load_use_i, ex_busy_i, if_stall_i, mem_stall_i,
        output stall_o, flush_o, jump_en_o, jump_addr_o, stall_cnt_o
    );

    modport slave (
        output jump_en_i, jump_addr_i, trap_en_i, trap_addr_i,
               load_use_i, ex_busy_i, if_stall_i, mem_stall_i,
        input  stall_o, flush_o, jump_en_o, jump_addr_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the stall-cycle performance counter.
// Ports: clk, rst (async, active-low), inc (count this edge),
//        clear (sync zero, wins over inc), cnt (current value).
// Sticks at all-ones; never wraps.
module pipe_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard/redirect controller for the 5-stage pipeline.
// Folds memory wait, EX busy, load-use, branch/jump and trap redirects
// into one prioritised stall/flush decision per cycle and drives the PC
// load. A redirect that meets a busy fetch is parked until IF is ready.
// Ports: clk, rst (async, active-low), ctrl (pipe_ctrl_if.master).
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal flow, redirects go straight to the PC when IF is ready
// PEND  | redirect parked in pend_addr_q, waiting for IF to accept it
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.master ctrl
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    stg_vec_t        stall, flush;
    logic            jump_en;
    logic [XLEN-1:0] jump_addr;
    logic [CNT_W-1:0] stall_cnt;

    always_comb begin
        stall       = STG_NONE;
        flush       = STG_NONE;
        jump_en     = 1'b0;
        jump_addr   = '0;
        state_d     = state_q;
        pend_addr_d = pend_addr_q;

        // Outputs are held quiet during reset so nothing downstream acts
        // on the decode of stale inputs.
        if (rst) begin
            unique case (state_q)
                RUN: begin
                    // A jump/trap under a memory wait is not consumed; the
                    // requester keeps it asserted and it is seen again later.
                    if (ctrl.mem_stall_i) begin
                        stall = STALL_MEM;
                        flush = FLUSH_MEM;
                    end else if (ctrl.trap_en_i || ctrl.jump_en_i) begin
                        flush = FLUSH_REDIR;
                        if (!ctrl.if_stall_i) begin
                            jump_en   = 1'b1;
                            jump_addr = ctrl.trap_en_i ? ctrl.trap_addr_i : ctrl.jump_addr_i;
                        end else begin
                            pend_addr_d = ctrl.trap_en_i ? ctrl.trap_addr_i : ctrl.jump_addr_i;
                            state_d     = PEND;
                        end
                    end else if (ctrl.ex_busy_i) begin
                        stall = STALL_EX;
                        flush = FLUSH_EX;
                    end else if (ctrl.load_use_i) begin
                        stall = STALL_LU;
                        flush = FLUSH_LU;
                    end else if (ctrl.if_stall_i) begin
                        stall = STALL_IF;
                        flush = FLUSH_IF;
                    end
                end
                PEND: begin
                    // A trap always replaces a parked jump target.
                    if (ctrl.trap_en_i) begin
                        pend_addr_d = ctrl.trap_addr_i;
                    end
                    if (ctrl.mem_stall_i) begin
                        stall = STALL_MEM;
                        flush = FLUSH_PEND_MEM;
                    end else begin
                        stall = STALL_PEND;
                        flush = FLUSH_PEND;
                        if (!ctrl.if_stall_i) begin
                            jump_en   = 1'b1;
                            jump_addr = ctrl.trap_en_i ? ctrl.trap_addr_i : pend_addr_q;
                            state_d   = RUN;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // EX is flushed behind a parked redirect, so a new jump there means
    // the datapath ignored the flush.
    assert property (@(posedge clk) disable iff (!rst)
                     (state_q == PEND) |-> !ctrl.jump_en_i)
        else $error("jump_en_i asserted while a redirect is pending");

    pipe_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (|stall),
        .clear (1'b0),
        .cnt   (stall_cnt)
    );

    assign ctrl.stall_o     = stall;
    assign ctrl.flush_o     = flush;
    assign ctrl.jump_en_o   = jump_en;
    assign ctrl.jump_addr_o = jump_addr;
    assign ctrl.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Expected outputs for each cycle are pushed
// to a scoreboard queue when the stimulus is applied and popped/compared
// at the following falling edge. A second instance with a 4-bit counter
// exercises counter saturation.
module tb_pipe_ctrl;

    typedef struct {
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        jen;
        logic [63:0] addr;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    logic [31:0] model_cnt;

    pipe_ctrl_if #(.XLEN(64), .CNT_W(32)) bus ();
    pipe_ctrl_if #(.XLEN(64), .CNT_W(4))  sat_bus ();

    pipe_ctrl #(.XLEN(64), .CNT_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    pipe_ctrl #(.XLEN(64), .CNT_W(4)) dut_sat (
        .clk  (clk),
        .rst  (rst),
        .ctrl (sat_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic jen, input logic [63:0] jaddr,
                         input logic ten, input logic [63:0] taddr,
                         input logic lu, input logic exb,
                         input logic ifs, input logic ms);
        bus.jump_en_i   = jen;
        bus.jump_addr_i = jaddr;
        bus.trap_en_i   = ten;
        bus.trap_addr_i = taddr;
        bus.load_use_i  = lu;
        bus.ex_busy_i   = exb;
        bus.if_stall_i  = ifs;
        bus.mem_stall_i = ms;
    endtask

    // One cycle: queue the expectation, compare at the falling edge, advance
    // the counter model, then return just after the next rising edge.
    task automatic step(input string tag, input logic [4:0] e_stall, input logic [4:0] e_flush,
                        input logic e_jen, input logic [63:0] e_addr);
        exp_t e;
        exp_q.push_back('{stall: e_stall, flush: e_flush, jen: e_jen, addr: e_addr, cnt: model_cnt});
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ".stall"}, 64'(bus.stall_o), 64'(e.stall));
        check({tag, ".flush"}, 64'(bus.flush_o), 64'(e.flush));
        check({tag, ".jen"},   64'(bus.jump_en_o), 64'(e.jen));
        check({tag, ".addr"},  bus.jump_addr_o, e.addr);
        check({tag, ".cnt"},   64'(bus.stall_cnt_o), 64'(e.cnt));
        if (|e_stall) model_cnt = model_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_cnt = '0;
        rst       = 1'b0;
        sat_bus.jump_en_i   = 1'b0;
        sat_bus.jump_addr_i = '0;
        sat_bus.trap_en_i   = 1'b0;
        sat_bus.trap_addr_i = '0;
        sat_bus.load_use_i  = 1'b0;
        sat_bus.ex_busy_i   = 1'b0;
        sat_bus.if_stall_i  = 1'b0;
        sat_bus.mem_stall_i = 1'b0;

        // Busy inputs during reset must not leak to the outputs.
        drive(1'b1, 64'h8000_0040, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        step("in_reset", 5'b00000, 5'b00000, 1'b0, '0);

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("idle", 5'b00000, 5'b00000, 1'b0, '0);

        // Zero-latency jump.
        drive(1'b1, 64'h8000_0040, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("jump_now", 5'b00000, 5'b00110, 1'b1, 64'h8000_0040);

        // Jump under a busy fetch parks, then fires when IF is ready.
        drive(1'b1, 64'h8000_0100, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("jump_park", 5'b00000, 5'b00110, 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("pend_wait1", 5'b00001, 5'b00010, 1'b0, '0);
        step("pend_wait2", 5'b00001, 5'b00010, 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("pend_fire", 5'b00001, 5'b00010, 1'b1, 64'h8000_0100);
        check("pend_cnt_plus3", 64'(bus.stall_cnt_o), 64'd3);

        // Trap in PEND replaces the parked jump target.
        drive(1'b1, 64'h8000_0200, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("jump_park2", 5'b00000, 5'b00110, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b1, 1'b0);
        step("pend_trap", 5'b00001, 5'b00010, 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("pend_fire_trap", 5'b00001, 5'b00010, 1'b1, 64'h8000_0004);

        // Memory wait in PEND, then a same-cycle trap wins the redirect.
        drive(1'b1, 64'h8000_0300, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("jump_park3", 5'b00000, 5'b00110, 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("pend_mem", 5'b01111, 5'b10010, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 64'h8000_0008, 1'b0, 1'b0, 1'b0, 1'b0);
        step("pend_trap_now", 5'b00001, 5'b00010, 1'b1, 64'h8000_0008);

        // Priority in RUN.
        drive(1'b1, 64'h8000_0400, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("mem_over_jump", 5'b01111, 5'b10000, 1'b0, '0);
        drive(1'b1, 64'h8000_0400, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("jump_after_mem", 5'b00000, 5'b00110, 1'b1, 64'h8000_0400);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("load_use", 5'b00011, 5'b00100, 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        step("ex_busy", 5'b00111, 5'b01000, 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("if_stall", 5'b00001, 5'b00010, 1'b0, '0);
        drive(1'b1, 64'h8000_0500, 1'b1, 64'h8000_0010, 1'b1, 1'b1, 1'b0, 1'b0);
        step("trap_over_jump", 5'b00000, 5'b00110, 1'b1, 64'h8000_0010);

        // Reset while a redirect is parked: quiet at once, nothing after release.
        drive(1'b1, 64'h8000_0600, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("jump_park4", 5'b00000, 5'b00110, 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        model_cnt = '0;
        step("rst_in_pend", 5'b00000, 5'b00000, 1'b0, '0);
        rst = 1'b1;
        step("after_rst1", 5'b00000, 5'b00000, 1'b0, '0);
        step("after_rst2", 5'b00000, 5'b00000, 1'b0, '0);

        // Saturation on the 4-bit instance.
        sat_bus.if_stall_i = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("sat_near_max", 64'(sat_bus.stall_cnt_o), 64'hE);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold", 64'(sat_bus.stall_cnt_o), 64'hF);
        check("sat_stall_still", 64'(sat_bus.stall_o), 64'(5'b00001));
        sat_bus.if_stall_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard/redirect controller for the 5-stage RV64 pipeline (IF, ID, EX, MEM, WB).
- Merges the following into one prioritised decision per cycle:
  - memory wait, multi-cycle EX busy, load-use hazard, branch/jump redirect and trap redirect.
- Drives per-stage stall and flush vectors plus the PC redirect.
- Holds a redirect that arrives while a fetch is in flight until IF can accept it.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- XLEN, 64, address width of redirect targets
- CNT_W, 32, width of stall-cycle counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- jump_en_i  in  1  EX resolved taken branch/jump
- jump_addr_i  in  XLEN  EX redirect target
- trap_en_i  in  1  trap/exception redirect request
- trap_addr_i  in  XLEN  trap vector target
- load_use_i  in  1  ID detected load-use hazard
- ex_busy_i  in  1  multi-cycle EX op (mul/div) not finished
- if_stall_i  in  1  instruction fetch not ready
- mem_stall_i  in  1  data memory access not ready
- stall_o  out  5  freeze pipeline register; [0]=PC,[1]=IF/ID,[2]=ID/EX,[3]=EX/MEM,[4]=MEM/WB
- flush_o  out  5  insert bubble into same-indexed register
- jump_en_o  out  1  PC load strobe
- jump_addr_o  out  XLEN  PC load value
- stall_cnt_o  out  CNT_W  cycles with any stall_o bit set

Behaviour:
- Reset (rst=0, async): state=RUN; pend_addr_q=0; stall_cnt_o=0.
  - While in reset, all combinational outputs are forced to 0: stall_o, flush_o, jump_en_o, jump_addr_o.
- States: RUN, PEND.
- RUN priority, highest first; exactly one row applies:
  1. mem_stall_i: stall=5'b01111, flush=5'b10000, no redirect. Any jump/trap stays asserted upstream and is re-evaluated later.
  2. trap_en_i: flush=5'b00110, stall=0.
     - if_stall_i=0: jump_en_o=1, jump_addr_o=trap_addr_i.
     - if_stall_i=1: latch trap_addr_i into pend_addr_q, go to PEND, jump_en_o=0.
  3. jump_en_i: same as trap, using jump_addr_i.
  4. ex_busy_i: stall=5'b00111, flush=5'b01000.
  5. load_use_i: stall=5'b00011, flush=5'b00100.
  6. if_stall_i: stall=5'b00001, flush=5'b00010.
  7. otherwise: all zero.
- Redirect in RUN is zero-latency (combinational) when IF is ready.
- PEND:
  - Each cycle: flush[1]=1 (drop the in-flight fetch) and stall[0]=1.
  - trap_en_i in PEND: overwrite pend_addr_q with trap_addr_i. Trap beats pending jump.
  - jump_en_i in PEND: ignored. EX holds a bubble, so a jump here is illegal and flagged by an assertion.
  - mem_stall_i in PEND: stall=5'b01111, flush=5'b10010, remain in PEND, no redirect.
  - if_stall_i=0 and mem_stall_i=0: jump_en_o=1, jump_addr_o=pend_addr_q, return to RUN next edge.
    - If trap_en_i is also set that cycle, jump_addr_o=trap_addr_i.
- jump_addr_o=0 whenever jump_en_o=0.
- stall_cnt_o increments on every edge where |stall_o=1. It saturates at all-ones and never wraps.
- Reset asserted mid-PEND discards the pending address; no redirect is issued after reset release.

Decomposition:
- Shared package holds:
  - stage index constants: STG_PC=0, STG_IFID=1, STG_IDEX=2, STG_EXMEM=3, STG_MEMWB=4
  - state enum {RUN, PEND}
  - stall/flush pattern constants per hazard class
- Sub-module sat_counter (width CNT_W, inc, clear) for stall_cnt_o. All other logic stays flat.

Test Plan:
- Reset release, all inputs 0 -> stall_o=0, flush_o=0, jump_en_o=0, stall_cnt_o=0 for 10 cycles.
- jump_en_i=1, jump_addr_i=0x8000_0040, if_stall_i=0 -> same cycle jump_en_o=1, jump_addr_o=0x8000_0040, flush_o=5'b00110; stall_cnt_o unchanged.
- jump_en_i=1 to 0x8000_0100 with if_stall_i=1 held for 3 cycles -> 3 cycles in PEND with flush_o[1]=1 and stall_o[0]=1. On the cycle if_stall_i drops: jump_en_o=1, addr 0x8000_0100. stall_cnt_o=+3.
- In PEND, trap_en_i=1 with trap_addr_i=0x8000_0004 -> the later redirect uses 0x8000_0004.
- mem_stall_i=1, jump_en_i=1, load_use_i=1 together -> stall_o=5'b01111, flush_o=5'b10000, jump_en_o=0. After mem_stall_i drops, the jump fires.
- Force stall_cnt_o to all-ones-1, stall for 3 cycles -> counter holds at all-ones. Assert rst low mid-PEND -> all outputs 0 immediately; no jump_en_o after release.
